// File: rtl/bisc_pkg.sv
// Shared constants and state encoding for the BISC-MVM MAC lane.
// Sized for 8-bit operands and a 256-count selector sequence.
package bisc_pkg;

  localparam int BIN_LEN   = 8;
  localparam int BIN_WIDTH = 3;
  localparam int SC_LEN    = 256;
  localparam int ACC_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } mac_state_t;

endpackage

// File: rtl/bisc_sign_acc.sv
// Signed dot-product accumulator: adds or subtracts one bit per enabled cycle.
// Arithmetic wraps at ACC_WIDTH bits; clear has priority over accumulate.
module bisc_sign_acc #(
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic                 i_neg,
  input  logic                 i_bit,
  output logic [ACC_WIDTH-1:0] o_acc
);

  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] w_mag;
  logic [ACC_WIDTH-1:0] w_step;

  assign w_mag  = ACC_WIDTH'(i_bit);
  assign w_step = i_neg ? -w_mag : w_mag;

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_step;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/bisc_mac_lane.sv
// Control/accumulate stage behind the selector FSM: runs the selector for |w|
// cycles per (x, w) pair and accumulates +/- x[selector] into a dot product.
module bisc_mac_lane #(
  parameter int BIN_LEN   = 8,
  parameter int BIN_WIDTH = 3,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIN_LEN-1:0]   in_x,
  input  logic [BIN_LEN-1:0]   in_w,
  input  logic                 in_last,
  output logic                 sel_enable,
  output logic                 sel_reset,
  input  logic [BIN_WIDTH-1:0] selector,
  input  logic                 zero_select,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 err
);

  import bisc_pkg::*;

  mac_state_t           r_state;
  mac_state_t           w_next;
  logic [BIN_LEN-1:0]   r_x;
  logic [BIN_LEN-1:0]   r_rem;
  logic [BIN_LEN-1:0]   w_abs_w;
  logic                 r_neg;
  logic                 r_last;
  logic                 r_err;
  logic                 w_hs;
  logic                 w_run;
  logic                 w_bit;
  logic                 w_acc_clr;
  logic [ACC_WIDTH-1:0] w_acc;

  // -128 negates to 8'h80, which read unsigned is the wanted 128.
  assign w_abs_w   = in_w[BIN_LEN-1] ? -in_w : in_w;
  assign w_hs      = in_valid && (r_state == IDLE);
  assign w_run     = (r_state == RUN);
  assign w_bit     = r_x[selector];
  assign w_acc_clr = (r_state == DONE) && out_ready;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (w_abs_w != '0)  w_next = CLR;
          else if (in_last)   w_next = DONE;
        end
      end
      CLR:  w_next = RUN;
      RUN:  if (r_rem == BIN_LEN'(1)) w_next = r_last ? DONE : IDLE;
      DONE: if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_rem   <= '0;
      r_neg   <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_hs) begin
        r_x    <= in_x;
        r_neg  <= in_w[BIN_LEN-1];
        r_rem  <= w_abs_w;
        r_last <= in_last;
      end else if (w_run) begin
        r_rem <= r_rem - BIN_LEN'(1);
      end
      // |w| never reaches the selector's final count, so seeing it in RUN means the selector wrapped.
      if (w_run && zero_select) r_err <= 1'b1;
    end
  end

  bisc_sign_acc #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_acc (
    .clock (clock),
    .reset (reset),
    .i_clr (w_acc_clr),
    .i_en  (w_run),
    .i_neg (r_neg),
    .i_bit (w_bit),
    .o_acc (w_acc)
  );

  assign in_ready   = (r_state == IDLE);
  assign sel_reset  = (r_state == CLR);
  assign sel_enable = w_run;
  assign out_valid  = (r_state == DONE);
  assign out_data   = w_acc;
  assign err        = r_err;

endmodule
